// File: rtl/deskew_align.sv
// deskew_align: realigns a word whose lanes arrive with a fixed skew.
// Lane k of a word arrives k cycles after lane 0. Lane k is delayed by
// (size-1-k) register stages so every lane of a word lines up, and then
// one common output register produces bus_out/valid_out.
//
// Optional feature: define DESKEW_COUNT_EN to add a burst counter
// (row_count, done) that counts aligned words modulo rows.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      synchronous active-high reset
//   bus_in     skewed lane words, lane k at [k*data_size +: data_size]
//   valid_in   per-lane valid
//   bus_out    realigned word, same packing as bus_in
//   valid_out  one-cycle qualifier for bus_out
//   row_count  aligned words in current burst (DESKEW_COUNT_EN only)
//   done       burst-complete pulse (DESKEW_COUNT_EN only)
//   error      sticky lane-misalignment flag
module deskew_align #(
    parameter int unsigned data_size = 16,
    parameter int unsigned size = 4,
    parameter int unsigned rows = 4,
    parameter logic [data_size-1:0] default_value = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [data_size*size-1:0]      bus_in,
    input  logic [size-1:0]                valid_in,
    output logic [data_size*size-1:0]      bus_out,
    output logic                           valid_out,
`ifdef DESKEW_COUNT_EN
    output logic [$clog2(rows+1)-1:0]      row_count,
    output logic                           done,
`endif
    output logic                           error
);

    // Parameter legality checked at elaboration.
    if (size < 1 || size > 32) begin : g_bad_size
        $error("deskew_align: size must be in 1..32");
    end
    if (rows < 1) begin : g_bad_rows
        $error("deskew_align: rows must be at least 1");
    end

    logic [data_size*size-1:0] aligned_data;
    logic [size-1:0]           aligned_valid;
    logic                      all_valid;
    logic                      any_valid;

    for (genvar k = 0; k < int'(size); k++) begin : g_lane
        localparam int unsigned Depth = size - 1 - k;

        if (Depth == 0) begin : g_direct
            // Last lane arrives already aligned; only the output register applies.
            assign aligned_data[k*data_size +: data_size] = bus_in[k*data_size +: data_size];
            assign aligned_valid[k]                       = valid_in[k];
        end else begin : g_pipe
            logic [data_size-1:0] pipe_q [Depth];
            logic [Depth-1:0]     vpipe_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < Depth; i++) begin
                        pipe_q[i] <= default_value;
                    end
                    vpipe_q <= '0;
                end else begin
                    pipe_q[0]  <= bus_in[k*data_size +: data_size];
                    vpipe_q[0] <= valid_in[k];
                    for (int unsigned i = 1; i < Depth; i++) begin
                        pipe_q[i]  <= pipe_q[i-1];
                        vpipe_q[i] <= vpipe_q[i-1];
                    end
                end
            end

            assign aligned_data[k*data_size +: data_size] = pipe_q[Depth-1];
            assign aligned_valid[k]                       = vpipe_q[Depth-1];
        end
    end

    assign all_valid = &aligned_valid;
    assign any_valid = |aligned_valid;

    // Output register: data only loads on a fully valid word, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out   <= {size{default_value}};
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= all_valid;
            if (all_valid) begin
                bus_out <= aligned_data;
            end
            // Partial valid set means lanes slipped relative to each other.
            if (any_valid && !all_valid) begin
                error <= 1'b1;
            end
        end
    end

`ifdef DESKEW_COUNT_EN
    localparam int unsigned CountW = $clog2(rows + 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (all_valid) begin
                if (row_count == CountW'(rows - 1)) begin
                    row_count <= '0;
                    done      <= 1'b1;
                end else begin
                    row_count <= row_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/deskew_align.md
DESKEW_ALIGN -- requirements
Module: deskew_align

Interface
REQ-001 Parameter data_size, default 16: width of one lane word in bits.
REQ-002 Parameter size, default 4: number of lanes; legal range 1 to 32.
REQ-003 Parameter rows, default 4: aligned words per burst, used by the counter feature only; minimum 1.
REQ-004 Parameter default_value, default 0: per-lane word value loaded at reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 bus_in  input  data_size*size  skewed lane words; lane k occupies bits [k*data_size +: data_size].
REQ-008 valid_in  input  size  per-lane valid; bit k qualifies lane k of bus_in.
REQ-009 bus_out  output  data_size*size  realigned word with the same lane packing as bus_in.
REQ-010 valid_out  output  1  one-cycle qualifier for bus_out.
REQ-011 error  output  1  sticky lane-misalignment flag.
REQ-012 row_count  output  $clog2(rows+1)  aligned words in the current burst; present only with DESKEW_COUNT_EN.
REQ-013 done  output  1  burst-complete pulse; present only with DESKEW_COUNT_EN.

Function
REQ-014 Input skew is fixed: lane k data and valid arrive exactly k cycles after lane 0 data of the same word.
REQ-015 The block delays lane k data and valid by (size-1-k) register stages, then applies one common output register.
REQ-016 Latency is size cycles from lane 0 capture, and 1 cycle from lane size-1 capture, to the matching valid_out.
REQ-017 valid_out is 1 in a cycle only if all size aligned valid bits were 1 at the output-register edge.
REQ-018 bus_out loads the aligned word only on edges where valid_out is set; otherwise it holds its last value.
REQ-019 If the aligned valid bits are neither all 0 nor all 1, error becomes 1 and stays 1 until reset.
REQ-020 On a misaligned edge, valid_out is 0 and bus_out holds.
REQ-021 Back-to-back words, with lane 0 valid on consecutive cycles, produce valid_out on consecutive cycles with no bubbles.
REQ-022 With size=1 there are no skew stages: valid_out equals valid_in delayed 1 cycle, and error never sets.
REQ-023 There is no backpressure; the block accepts one word per lane per cycle unconditionally.

Reset
REQ-024 On a reset edge, all skew stages load default_value and their valid bits load 0.
REQ-025 On a reset edge, bus_out loads default_value in every lane, and valid_out, error, row_count and done load 0.
REQ-026 Reset mid-burst discards every partially skewed word.
REQ-027 After reset deasserts, valid_out stays 0 until a complete word, all lanes valid, has traversed the skew stages.
REQ-028 Reset has priority over every simultaneous input event.

Configuration
REQ-029 Macro DESKEW_COUNT_EN controls the burst counter feature.
REQ-030 With DESKEW_COUNT_EN defined, row_count increments by 1 on each valid_out.
REQ-031 With DESKEW_COUNT_EN defined, the valid_out that brings the count to rows also asserts done for that cycle and returns row_count to 0 on the same edge.
REQ-032 With DESKEW_COUNT_EN undefined, row_count, done and the counter logic are absent, and all other behaviour is identical.

Verification
REQ-033 size=4, data 16'h000k on lane k, lane 0 valid at cycle 10 -> valid_out=1 at cycle 14, bus_out=64'h0003_0002_0001_0000, error=0.
REQ-034 size=4, 6 consecutive words, lane 0 valid at cycles 10-15 -> valid_out=1 at cycles 14-19, words in order, no gaps.
REQ-035 size=4, lane 2 valid dropped for one word -> valid_out=0 for that slot, error=1 and sticky, bus_out holds the previous word.
REQ-036 Reset pulsed at cycle 12 mid-word -> valid_out=0 at cycles 13-14, bus_out=default_value in every lane, error=0.
REQ-037 DESKEW_COUNT_EN, rows=4, 5 words -> row_count 1,2,3,0,1 on successive valid_out, done=1 only with the 4th word.
REQ-038 size=1, valid_in=1 with data 16'hABCD at cycle 5 -> valid_out=1 and bus_out=16'hABCD at cycle 6.
